riscv_core_muldiv_iter_param: RTL and testbench

- Parametrised iterative multiply/divide unit for the RISC-V core datapath; successor to the fixed 32-bit pipelined muldiv.
- Supports configurable operand width (XLEN) and configurable bits retired per iteration (BPC).
- Adds RISC-V divide-by-zero and overflow semantics, single-cycle early-out for trivial operations, and a flush input for squashed instructions.
- Sits between X-stage operand muxing and the writeback result mux, using val/rdy handshakes on both request and response.

---
 rtl/riscv_core_muldiv_iter_param.sv | 209 ++++++++++++++++++++
 tb/tb_riscv_core_muldiv_iter_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_muldiv_iter_param.sv
// Iterative multiply/divide unit: BPC bits per cycle over XLEN-bit operands,
// with RISC-V div-by-zero/overflow semantics, early-out and flush.
`timescale 1ns/1ps

module riscv_core_muldiv_iter_param #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned BPC  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        muldivreq_msg_fn,
   input  logic [XLEN-1:0]   muldivreq_msg_a,
   input  logic [XLEN-1:0]   muldivreq_msg_b,
   input  logic              muldivreq_val,
   output logic              muldivreq_rdy,
   output logic [2*XLEN-1:0] muldivresp_msg_result,
   output logic              muldivresp_val,
   input  logic              muldivresp_rdy,
   input  logic              flush,
   output logic              busy
);

   localparam int unsigned K  = XLEN / BPC;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   if (XLEN < 8 || (XLEN % 2) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4) ||
       (XLEN % BPC) != 0) begin : g_bad_param
      $error("riscv_core_muldiv_iter_param: illegal XLEN/BPC combination");
   end

   typedef enum logic [2:0] {
      FN_MUL  = 3'd0,
      FN_DIV  = 3'd1,
      FN_DIVU = 3'd2,
      FN_REM  = 3'd3,
      FN_REMU = 3'd4
   } fn_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              is_mul_q, is_mul_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [2*XLEN-1:0] result_q, result_d;

   // Request decode: magnitudes and sign flags for the signed ops
   logic              req_mul, req_sdiv, req_udiv;
   logic              sign_a, sign_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              early;
   logic [2*XLEN-1:0] early_res;

   always_comb begin
      req_mul  = (muldivreq_msg_fn == FN_MUL);
      req_sdiv = (muldivreq_msg_fn == FN_DIV)  || (muldivreq_msg_fn == FN_REM);
      req_udiv = (muldivreq_msg_fn == FN_DIVU) || (muldivreq_msg_fn == FN_REMU);
      sign_a   = muldivreq_msg_a[XLEN-1] && (req_mul || req_sdiv);
      sign_b   = muldivreq_msg_b[XLEN-1] && (req_mul || req_sdiv);
      abs_a    = sign_a ? -muldivreq_msg_a : muldivreq_msg_a;
      abs_b    = sign_b ? -muldivreq_msg_b : muldivreq_msg_b;

      early     = 1'b0;
      early_res = '0;
      if (!(req_mul || req_sdiv || req_udiv)) begin
         early = 1'b1;
      end else if (req_mul && (muldivreq_msg_a == '0 || muldivreq_msg_b == '0)) begin
         early = 1'b1;
      end else if (!req_mul && muldivreq_msg_b == '0) begin
         early     = 1'b1;
         early_res = {muldivreq_msg_a, {XLEN{1'b1}}};
      end else if (req_sdiv && muldivreq_msg_a == SMIN && muldivreq_msg_b == '1) begin
         early     = 1'b1;
         early_res = {{XLEN{1'b0}}, muldivreq_msg_a};
      end
   end

   // One CALC cycle = BPC shift-add (mul) or restoring-subtract (div) steps
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;

   always_comb begin
      // NOTE: every comb output gets a default first, so no latch is inferred.
      step_acc = acc_q;
      add_sum  = '0;
      rem_sh   = '0;
      diff     = '0;
      for (int i = 0; i < int'(BPC); i++) begin
         if (is_mul_q) begin
            add_sum  = {1'b0, step_acc[2*XLEN-1:XLEN]} +
                       (step_acc[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
            step_acc = {add_sum, step_acc[XLEN-1:1]};
         end else begin
            rem_sh = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
            diff   = rem_sh - {1'b0, opb_q};
            if (!diff[XLEN]) begin
               step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
            end else begin
               step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
            end
         end
      end
   end

   // Sign correction applied in FIX
   logic [2*XLEN-1:0] fix_res;
   logic [XLEN-1:0]   quot, remd;

   always_comb begin
      quot = acc_q[XLEN-1:0];
      remd = acc_q[2*XLEN-1:XLEN];
      if (is_mul_q) begin
         fix_res = neg_res_q ? -acc_q : acc_q;
      end else begin
         fix_res = {(neg_rem_q ? -remd : remd), (neg_res_q ? -quot : quot)};
      end
   end

   assign muldivreq_rdy         = (state_q == S_IDLE) && !flush;
   assign muldivresp_val        = (state_q == S_DONE);
   assign busy                  = (state_q != S_IDLE);
   assign muldivresp_msg_result = result_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      cnt_d     = cnt_q;
      is_mul_d  = is_mul_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (muldivreq_val && muldivreq_rdy) begin
                  is_mul_d  = req_mul;
                  neg_res_d = sign_a ^ sign_b;
                  neg_rem_d = sign_a && !req_mul;
                  acc_d     = {{XLEN{1'b0}}, (req_mul ? abs_b : abs_a)};
                  opb_d     = req_mul ? abs_a : abs_b;
                  cnt_d     = CW'(K - 1);
                  if (early) begin
                     result_d = early_res;
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               result_d = fix_res;
               state_d  = S_DONE;
            end
            S_DONE: begin
               if (muldivresp_rdy) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         is_mul_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         cnt_q     <= cnt_d;
         is_mul_q  <= is_mul_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_riscv_core_muldiv_iter_param.sv
// Directed vector bench for riscv_core_muldiv_iter_param at XLEN=32/BPC=1
// and XLEN=8/BPC=4: results, latency, stall hold, flush and async reset.
`timescale 1ns/1ps

module tb_riscv_core_muldiv_iter_param;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-bit instance
   logic [2:0]  fn32;
   logic [31:0] a32, b32;
   logic        val32, req_rdy32, resp_val32, resp_rdy32, flush32, busy32;
   logic [63:0] result32;

   // 8-bit instance
   logic [2:0]  fn8;
   logic [7:0]  a8, b8;
   logic        val8, req_rdy8, resp_val8, resp_rdy8, flush8, busy8;
   logic [15:0] result8;

   riscv_core_muldiv_iter_param #(.XLEN(32), .BPC(1)) dut32 (
      .clk                   (clk),
      .reset                 (rst_n),
      .muldivreq_msg_fn      (fn32),
      .muldivreq_msg_a       (a32),
      .muldivreq_msg_b       (b32),
      .muldivreq_val         (val32),
      .muldivreq_rdy         (req_rdy32),
      .muldivresp_msg_result (result32),
      .muldivresp_val        (resp_val32),
      .muldivresp_rdy        (resp_rdy32),
      .flush                 (flush32),
      .busy                  (busy32)
   );

   riscv_core_muldiv_iter_param #(.XLEN(8), .BPC(4)) dut8 (
      .clk                   (clk),
      .reset                 (rst_n),
      .muldivreq_msg_fn      (fn8),
      .muldivreq_msg_a       (a8),
      .muldivreq_msg_b       (b8),
      .muldivreq_val         (val8),
      .muldivreq_rdy         (req_rdy8),
      .muldivresp_msg_result (result8),
      .muldivresp_val        (resp_val8),
      .muldivresp_rdy        (resp_rdy8),
      .flush                 (flush8),
      .busy                  (busy8)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   // One request/response on the 32-bit unit with source delay and sink stall
   task automatic do_op32(input vec_t v, input int src_dly, input int stall);
      int lat;
      int waited;
      repeat (src_dly) @(negedge clk);
      fn32 = v.fn; a32 = v.a; b32 = v.b; val32 = 1'b1;
      resp_rdy32 = (stall == 0);
      waited = 0;
      while (!req_rdy32 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      // Garbage on the operand bus after acceptance must be ignored
      val32 = 1'b0; fn32 = 3'd1; a32 = 32'hA5A5_5A5A; b32 = 32'h5A5A_A5A5;
      lat = 1;
      while (!resp_val32 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, 64'(lat), 64'(v.lat));
      check({v.name, " result"}, result32, v.exp);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({v.name, " held val"}, 64'(resp_val32), 64'd1);
         check({v.name, " held result"}, result32, v.exp);
      end
      resp_rdy32 = 1'b1;
      @(negedge clk);
      check({v.name, " released"}, 64'(resp_val32), 64'd0);
      resp_rdy32 = 1'b0;
   endtask

   task automatic do_op8(input string name, input logic [2:0] fn, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp, input int exp_lat);
      int lat;
      fn8 = fn; a8 = a; b8 = b; val8 = 1'b1; resp_rdy8 = 1'b1;
      @(negedge clk);
      val8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
      lat = 1;
      while (!resp_val8 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " result"}, 64'(result8), 64'(exp));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      vec_t v;

      vecs[0]  = '{"mul deadbeef", 3'd0, 32'hdeadbeef, 32'h10000000, 64'hfdeadbee_f0000000, 34};
      vecs[1]  = '{"rem neg/neg",  3'd3, 32'hf5fe4fbc, 32'hffffb14a, 64'hffffcc8e_0000208b, 34};
      vecs[2]  = '{"divu beef",    3'd2, 32'hdeadbeef, 32'h0000beef, 64'h0000227f_00012a90, 34};
      vecs[3]  = '{"div by zero",  3'd1, 32'h00000005, 32'h00000000, 64'h00000005_ffffffff, 1};
      vecs[4]  = '{"div overflow", 3'd1, 32'h80000000, 32'hffffffff, 64'h00000000_80000000, 1};
      vecs[5]  = '{"mul zero",     3'd0, 32'h00000000, 32'h00000007, 64'h0, 1};
      vecs[6]  = '{"mul 3x5",      3'd0, 32'h00000003, 32'h00000005, 64'h00000000_0000000f, 34};
      vecs[7]  = '{"mul -1x-1",    3'd0, 32'hffffffff, 32'hffffffff, 64'h00000000_00000001, 34};
      vecs[8]  = '{"mul -2x3",     3'd0, 32'hfffffffe, 32'h00000003, 64'hffffffff_fffffffa, 34};
      vecs[9]  = '{"div -7/2",     3'd1, 32'hfffffff9, 32'h00000002, 64'hffffffff_fffffffd, 34};
      vecs[10] = '{"divu big/2",   3'd2, 32'hfffffff9, 32'h00000002, 64'h00000001_7ffffffc, 34};
      vecs[11] = '{"rem 7/-2",     3'd3, 32'h00000007, 32'hfffffffe, 64'h00000001_fffffffd, 34};
      vecs[12] = '{"remu 100/7",   3'd4, 32'h00000064, 32'h00000007, 64'h00000002_0000000e, 34};
      vecs[13] = '{"divu by zero", 3'd2, 32'h00000005, 32'h00000000, 64'h00000005_ffffffff, 1};
      vecs[14] = '{"reserved fn",  3'd5, 32'h00001234, 32'h00005678, 64'h0, 1};
      vecs[15] = '{"mul min*min",  3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 34};
      vecs[16] = '{"div min/2",    3'd1, 32'h80000000, 32'h00000002, 64'h00000000_c0000000, 34};
      vecs[17] = '{"mul max*max",  3'd0, 32'h7fffffff, 32'h7fffffff, 64'h3fffffff_00000001, 34};
      vecs[18] = '{"rem by zero",  3'd3, 32'hfffffff0, 32'h00000000, 64'hfffffff0_ffffffff, 1};

      rst_n = 1'b0;
      fn32 = '0; a32 = '0; b32 = '0; val32 = 1'b0; resp_rdy32 = 1'b0; flush32 = 1'b0;
      fn8 = '0; a8 = '0; b8 = '0; val8 = 1'b0; resp_rdy8 = 1'b0; flush8 = 1'b0;
      repeat (3) @(negedge clk);

      check("reset req_rdy",  64'(req_rdy32), 64'd1);
      check("reset resp_val", 64'(resp_val32), 64'd0);
      check("reset result",   result32, 64'd0);
      check("reset busy",     64'(busy32), 64'd0);
      check("reset8 req_rdy", 64'(req_rdy8), 64'd1);
      check("reset8 busy",    64'(busy8), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Mixed ops with random source/sink delay, checked in issue order
      for (int i = 0; i < NV; i++) begin
         do_op32(vecs[i], int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      // Long sink stall: response held for 10 cycles
      do_op32(vecs[0], 0, 10);
      do_op32(vecs[3], 1, 10);

      // Flush 5 cycles into a divide, with a competing request that must be refused
      fn32 = 3'd1; a32 = 32'hdeadbeef; b32 = 32'h00001234; val32 = 1'b1; resp_rdy32 = 1'b1;
      @(negedge clk);
      val32 = 1'b0;
      check("div busy", 64'(busy32), 64'd1);
      repeat (4) @(negedge clk);
      flush32 = 1'b1; val32 = 1'b1; fn32 = 3'd0; a32 = 32'd3; b32 = 32'd5;
      #1;
      check("rdy low in flush", 64'(req_rdy32), 64'd0);
      @(negedge clk);
      flush32 = 1'b0; val32 = 1'b0;
      check("flush busy", 64'(busy32), 64'd0);
      check("flush resp_val", 64'(resp_val32), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_val32) seen++;
      end
      check("no resp after flush", 64'(seen), 64'd0);
      resp_rdy32 = 1'b0;
      do_op32(vecs[2], 0, 0);

      // Flush drops a held response
      fn32 = 3'd0; a32 = 32'd3; b32 = 32'd5; val32 = 1'b1; resp_rdy32 = 1'b0;
      @(negedge clk);
      val32 = 1'b0;
      seen = 0;
      while (!resp_val32 && seen < 100) begin
         @(negedge clk);
         seen++;
      end
      check("held resp before flush", 64'(resp_val32), 64'd1);
      flush32 = 1'b1;
      @(negedge clk);
      flush32 = 1'b0;
      check("flush drops resp", 64'(resp_val32), 64'd0);
      check("flush drops busy", 64'(busy32), 64'd0);

      // Asynchronous reset in the middle of CALC
      fn32 = 3'd2; a32 = 32'hdeadbeef; b32 = 32'h0000beef; val32 = 1'b1; resp_rdy32 = 1'b1;
      @(negedge clk);
      val32 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid reset req_rdy",  64'(req_rdy32), 64'd1);
      check("mid reset resp_val", 64'(resp_val32), 64'd0);
      check("mid reset result",   result32, 64'd0);
      check("mid reset busy",     64'(busy32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_val32) seen++;
      end
      check("no resp after reset", 64'(seen), 64'd0);
      resp_rdy32 = 1'b0;
      v = vecs[1];
      do_op32(v, 0, 0);

      // Narrow configuration: XLEN=8, BPC=4 gives K=2
      do_op8("mul8 f8x08",  3'd0, 8'hf8, 8'h08, 16'hffc0, 4);
      do_op8("rem8 7f/05",  3'd3, 8'h7f, 8'h05, 16'h0219, 4);
      do_op8("divu8 ff/10", 3'd2, 8'hff, 8'h10, 16'h0f0f, 4);
      do_op8("div8 ovf",    3'd1, 8'h80, 8'hff, 16'h0080, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
